// File: rtl/clock_one_pkg.sv
// Shared types and constants for the clock_one 24-hour clock: BCD time record,
// mode encodings, display-bus field positions and the 7-segment glyph table.
package clock_one_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    // Any value with bit1 set selects set mode; bit0 is then ignored.
    localparam int         MODE_SET_BIT = 1;

    localparam int NUM_DIGITS = 6;
    localparam int AN_MSB     = 13;
    localparam int AN_LSB     = 8;
    localparam int DP_BIT     = 7;
    localparam int SEG_MSB    = 6;
    localparam int SEG_LSB    = 0;

    localparam logic [13:0] OUTCR_RESET = 14'h3EC0;

    typedef struct packed {
        logic [1:0] hr_t;
        logic [3:0] hr_u;
        logic [2:0] min_t;
        logic [3:0] min_u;
        logic [2:0] sec_t;
        logic [3:0] sec_u;
    } bcd_time_t;

    // Active-low segments g..a; entry 0 is the rightmost.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic logic [6:0] seg_glyph(input logic [3:0] d);
        if (d > 4'd9) begin
            return 7'b1111111;
        end
        return SEG_TABLE[d];
    endfunction

    function automatic bcd_time_t inc_hours(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.hr_t == 2'd2 && t.hr_u == 4'd3) begin
            r.hr_t = 2'd0;
            r.hr_u = 4'd0;
        end else if (t.hr_u == 4'd9) begin
            r.hr_u = 4'd0;
            r.hr_t = t.hr_t + 2'd1;
        end else begin
            r.hr_u = t.hr_u + 4'd1;
        end
        return r;
    endfunction

    // Minutes wrap 59 -> 00 without touching the hours.
    function automatic bcd_time_t inc_minutes(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.min_u != 4'd9) begin
            r.min_u = t.min_u + 4'd1;
        end else begin
            r.min_u = 4'd0;
            r.min_t = (t.min_t == 3'd5) ? 3'd0 : t.min_t + 3'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/clock_one_debounce.sv
// Button conditioner: two-flop synchronizer, stable-level debounce counter and
// a single-cycle pulse on each accepted press (1 -> 0).
module clock_one_debounce
    import clock_one_pkg::*;
#(
    parameter int DEB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: both synchronizer stages reset to "released" so a held button
    // during reset is seen as a fresh press only after the full debounce time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // NOTE: every output of this block is given a default first; leaving one
    // unassigned on some path would infer a latch.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            level_d = sync2_q;
            cnt_d   = '0;
            press_d = ~sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/clock_one.sv
// 24-hour HH:MM:SS clock: 1 Hz prescaler, BCD time counters with set buttons,
// and a registered 6-digit multiplexed common-anode 7-segment driver.
module clock_one
    import clock_one_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int SCAN_DIV   = 50_000,
    parameter int DEB_CYCLES = 500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  swch,
    input  logic        BUT1,
    input  logic        BUT2,
    output logic [13:0] OUTCR
);

    localparam int PW = (CLK_HZ > 1)   ? $clog2(CLK_HZ)   : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic          hr_press, min_press;
    logic          running, set_mode, tick;
    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]    scan_idx_q, scan_idx_d;
    bcd_time_t     time_q, time_d;
    logic [13:0]   outcr_q, outcr_d;
    logic [3:0]    digit;
    logic          dp_on;

    clock_one_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_hr (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (BUT1),
        .press_o (hr_press)
    );

    clock_one_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_min (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (BUT2),
        .press_o (min_press)
    );

    assign running  = (swch == MODE_RUN);
    assign set_mode = swch[MODE_SET_BIT];
    assign tick     = running && (presc_q == PW'(CLK_HZ - 1));

    always_comb begin
        presc_d = '0;
        if (running && !tick) begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_comb begin
        time_d = time_q;
        if (tick) begin
            if (time_q.sec_u != 4'd9) begin
                time_d.sec_u = time_q.sec_u + 4'd1;
            end else begin
                time_d.sec_u = 4'd0;
                if (time_q.sec_t != 3'd5) begin
                    time_d.sec_t = time_q.sec_t + 3'd1;
                end else begin
                    time_d.sec_t = 3'd0;
                    time_d = inc_minutes(time_d);
                    if (time_q.min_t == 3'd5 && time_q.min_u == 4'd9) begin
                        time_d = inc_hours(time_d);
                    end
                end
            end
        end else if (set_mode) begin
            // Both buttons may land in the same cycle; apply hours then minutes.
            if (hr_press) begin
                time_d = inc_hours(time_d);
            end
            if (min_press) begin
                time_d       = inc_minutes(time_d);
                time_d.sec_t = 3'd0;
                time_d.sec_u = 4'd0;
            end
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            scan_idx_d = (scan_idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : scan_idx_q + 3'd1;
        end
    end

    always_comb begin
        case (scan_idx_q)
            3'd0:    digit = time_q.sec_u;
            3'd1:    digit = {1'b0, time_q.sec_t};
            3'd2:    digit = time_q.min_u;
            3'd3:    digit = {1'b0, time_q.min_t};
            3'd4:    digit = time_q.hr_u;
            default: digit = {2'b00, time_q.hr_t};
        endcase
        dp_on = (scan_idx_q == 3'd2 || scan_idx_q == 3'd4) &&
                (!running || presc_q < PW'(CLK_HZ / 2));
        outcr_d                  = '1;
        outcr_d[AN_MSB:AN_LSB]   = ~(6'b000001 << scan_idx_q);
        outcr_d[DP_BIT]          = ~dp_on;
        outcr_d[SEG_MSB:SEG_LSB] = seg_glyph(digit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            time_q     <= '0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            outcr_q    <= OUTCR_RESET;
        end else begin
            presc_q    <= presc_d;
            time_q     <= time_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            outcr_q    <= outcr_d;
        end
    end

    assign OUTCR = outcr_q;

endmodule

// File: tb/tb_clock_one.sv
// Self-checking bench for clock_one: directed scenarios plus random mode/button
// traffic, every cycle compared against a seconds-of-day reference model.
module tb_clock_one;

    localparam int CLK_HZ     = 10;
    localparam int SCAN_DIV   = 4;
    localparam int DEB_CYCLES = 3;
    localparam int HIST       = 8;

    logic        clk;
    logic        rst;
    logic [1:0]  swch;
    logic        BUT1;
    logic        BUT2;
    logic [13:0] OUTCR;

    int vectors;
    int miscompares;

    // Reference model state: time as seconds of day, length of the current
    // run streak, edges since reset, raw button history and accepted levels.
    int tod;
    int run_len;
    int edges;
    bit raw_hist [2][HIST];
    bit accepted [2];
    bit pend     [2];

    clock_one #(
        .CLK_HZ     (CLK_HZ),
        .SCAN_DIV   (SCAN_DIV),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .swch  (swch),
        .BUT1  (BUT1),
        .BUT2  (BUT2),
        .OUTCR (OUTCR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    task automatic model_reset();
        tod     = 0;
        run_len = 0;
        edges   = 0;
        for (int b = 0; b < 2; b++) begin
            accepted[b] = 1'b1;
            pend[b]     = 1'b0;
            for (int i = 0; i < HIST; i++) raw_hist[b][i] = 1'b1;
        end
    endtask

    // One clock edge: predict OUTCR from the pre-edge model state, advance the
    // model, then compare just after the edge.
    task automatic step();
        int          idx, h, m, s, dig;
        bit          running, dp_on, all_differ;
        bit          raw [2];
        logic [13:0] want;

        idx = (edges / SCAN_DIV) % 6;
        h = tod / 3600;
        m = (tod / 60) % 60;
        s = tod % 60;
        case (idx)
            0: dig = s % 10;
            1: dig = s / 10;
            2: dig = m % 10;
            3: dig = m / 10;
            4: dig = h % 10;
            default: dig = h / 10;
        endcase
        running = (swch == 2'b01);
        dp_on = (idx == 2 || idx == 4) && (!running || (run_len % CLK_HZ) < CLK_HZ / 2);
        want[13:8] = ~(6'b000001 << idx);
        want[7]    = ~dp_on;
        want[6:0]  = seg7(dig);

        if (running) begin
            run_len++;
            if (run_len % CLK_HZ == 0) tod = (tod + 1) % 86400;
        end else begin
            run_len = 0;
        end
        if (swch[1]) begin
            if (pend[0]) tod = ((h + 1) % 24) * 3600 + m * 60 + s;
            if (pend[1]) tod = (tod / 3600) * 3600 + ((m + 1) % 60) * 60;
        end

        // A level is accepted once the last DEB_CYCLES synchronized samples
        // (raw input delayed by two edges) all disagree with the current one.
        raw[0] = BUT1;
        raw[1] = BUT2;
        for (int b = 0; b < 2; b++) begin
            for (int i = HIST - 1; i > 0; i--) raw_hist[b][i] = raw_hist[b][i-1];
            raw_hist[b][0] = raw[b];
            all_differ = 1'b1;
            for (int i = 2; i < 2 + DEB_CYCLES; i++) begin
                if (raw_hist[b][i] == accepted[b]) all_differ = 1'b0;
            end
            pend[b] = 1'b0;
            if (all_differ) begin
                accepted[b] = raw_hist[b][2];
                pend[b]     = !raw_hist[b][2];
            end
        end
        edges++;

        @(posedge clk);
        #1;
        check("outcr", 32'(OUTCR), 32'(want));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("async_rst", 32'(OUTCR), 32'h3EC0);
        @(posedge clk);
        #1;
        check("rst_hold", 32'(OUTCR), 32'h3EC0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic press(input int btn, input int low_cyc, input int high_cyc);
        if (btn == 0) BUT1 = 1'b0; else BUT2 = 1'b0;
        run(low_cyc);
        if (btn == 0) BUT1 = 1'b1; else BUT2 = 1'b1;
        run(high_cyc);
    endtask

    task automatic presses(input int btn, input int n);
        repeat (n) press(btn, 5, 6);
    endtask

    // Wait (bounded) until digit position pos is selected, then check its glyph.
    task automatic check_digit(input string tag, input int pos, input logic [6:0] seg);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (OUTCR[13:8] == ~(6'b000001 << pos)) begin
                found = 1'b1;
                check(tag, 32'(OUTCR[6:0]), 32'(seg));
            end
        end
        if (!found) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst  = 1'b0;
        swch = 2'b00;
        BUT1 = 1'b1;
        BUT2 = 1'b1;
        model_reset();
        #1;
        do_reset();

        // Free run, then an asynchronous reset mid-count.
        swch = 2'b01;
        run(600);
        check_digit("min_u_after_600", 2, 7'b1111001);
        check_digit("min_t_after_600", 3, 7'b1000000);
        run(13);
        do_reset();

        // Set 23:59:00, then roll over midnight.
        swch = 2'b10;
        presses(0, 23);
        presses(1, 59);
        run(50);
        check_digit("set_hr_t_2", 5, 7'b0100100);
        check_digit("set_min_t_5", 3, 7'b0010010);
        swch = 2'b01;
        run(605);
        check_digit("wrap_hr_t", 5, 7'b1000000);
        check_digit("wrap_hr_u", 4, 7'b1000000);

        // Hours wrap 23 -> 00, minutes wrap 59 -> 00 without carry, reach 12:34.
        swch = 2'b10;
        presses(0, 24);
        check_digit("hr_wrap_u", 4, 7'b1000000);
        presses(0, 12);
        presses(1, 60);
        check_digit("min_wrap_hr_u", 4, 7'b0100100);
        check_digit("min_wrap_min_t", 3, 7'b1000000);
        presses(1, 34);

        // Simultaneous press applies both, then undo with wraps back to 12:34.
        BUT1 = 1'b0;
        BUT2 = 1'b0;
        run(6);
        BUT1 = 1'b1;
        BUT2 = 1'b1;
        run(6);
        presses(0, 23);
        presses(1, 59);

        // Debounce: short glitch rejected, bounce then stable gives one press.
        press(0, 2, 8);
        press(0, 1, 1);
        press(0, 1, 1);
        press(0, 8, 8);
        presses(0, 23);

        // Run to 12:34:56, freeze, inspect outer digits.
        swch = 2'b01;
        run(560);
        swch = 2'b00;
        check_digit("an5_12_34_56", 5, 7'b1111001);
        check_digit("an0_12_34_56", 0, 7'b0000010);
        run(100);
        swch = 2'b01;
        run(25);

        // Button presses outside set mode are ignored.
        press(0, 6, 6);
        swch = 2'b00;
        press(1, 6, 6);

        // Random mode and button traffic.
        repeat (40) begin
            swch = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 6)) begin
                BUT1 = 1'($urandom_range(0, 1));
                BUT2 = 1'($urandom_range(0, 1));
                run($urandom_range(1, 8));
            end
        end

        // Reset while running with a button held down.
        swch = 2'b01;
        BUT1 = 1'b0;
        run(7);
        do_reset();
        run(12);
        BUT1 = 1'b1;
        run(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
